// File: rtl/rr_arbiter.sv
// Round-robin / fixed-priority request arbiter with an optional hold-time limit.
// A grant is held until DONE, until the request drops, or until HOLD_MAX expires.
module rr_arbiter #(
  parameter int WIDTH    = 4,
  parameter int MODE     = 0,
  parameter int HOLD_MAX = 0
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       enable,
  input  logic [WIDTH-1:0]           req,
  input  logic                       done,
  output logic [WIDTH-1:0]           grant,
  output logic [$clog2(WIDTH)-1:0]   grant_idx,
  output logic                       busy,
  output logic                       timeout
);

  localparam int IDX_W     = $clog2(WIDTH);
  localparam int HC_W      = (HOLD_MAX > 0) ? $clog2(HOLD_MAX + 1) : 1;
  localparam int HOLD_LAST = (HOLD_MAX > 0) ? HOLD_MAX - 1 : 0;
  localparam logic [WIDTH-1:0] ONE_W = {{(WIDTH-1){1'b0}}, 1'b1};

  typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} state_t;

  state_t            state_r;
  logic [WIDTH-1:0]  base_r;
  logic [HC_W-1:0]   hold_cnt_r;
  logic [WIDTH-1:0]  masked_s;
  logic [WIDTH-1:0]  sel_s;
  logic              drop_s;
  logic              expire_s;
  logic              release_s;

  function automatic logic [WIDTH-1:0] lowest_one(input logic [WIDTH-1:0] v);
    lowest_one = v & (~v + ONE_W);
  endfunction

  function automatic logic [IDX_W-1:0] onehot_to_idx(input logic [WIDTH-1:0] v);
    onehot_to_idx = '0;
    for (int i = 0; i < WIDTH; i++) begin
      onehot_to_idx = onehot_to_idx | (v[i] ? IDX_W'(i) : IDX_W'(0));
    end
  endfunction

  // Next-winner search and release conditions
  always_comb begin
    masked_s = req & ~(base_r - ONE_W);
    if (masked_s != '0) begin
      sel_s = lowest_one(masked_s);
    end else begin
      sel_s = lowest_one(req);
    end
    drop_s    = ((req & grant) == '0);
    expire_s  = (HOLD_MAX > 0) && (hold_cnt_r == HC_W'(HOLD_LAST));
    release_s = done || drop_s || expire_s;
  end

  // Arbitration FSM with registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= IDLE;
      base_r     <= ONE_W;
      hold_cnt_r <= '0;
      grant      <= '0;
      grant_idx  <= '0;
      busy       <= 1'b0;
      timeout    <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          timeout <= 1'b0;
          if (enable && (req != '0)) begin
            state_r    <= GRANT;
            grant      <= sel_s;
            grant_idx  <= onehot_to_idx(sel_s);
            busy       <= 1'b1;
            hold_cnt_r <= '0;
          end
        end
        GRANT: begin
          if (release_s) begin
            state_r   <= IDLE;
            grant     <= '0;
            grant_idx <= '0;
            busy      <= 1'b0;
            // A same-cycle DONE or request drop counts as a normal release
            timeout   <= expire_s && !done && !drop_s;
            if (MODE == 0) begin
              base_r <= {grant[WIDTH-2:0], grant[WIDTH-1]};
            end else begin
              base_r <= ONE_W;
            end
          end else begin
            timeout <= 1'b0;
            if (hold_cnt_r != {HC_W{1'b1}}) begin
              hold_cnt_r <= hold_cnt_r + HC_W'(1);
            end
          end
        end
        default: begin
          state_r   <= IDLE;
          grant     <= '0;
          grant_idx <= '0;
          busy      <= 1'b0;
          timeout   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rr_arbiter.sv
// Scoreboard bench: three arbiter instances (round-robin, fixed priority, HOLD_MAX=8)
// driven one at a time; a monitor checks every grant change against a queue of expected events.
module tb_rr_arbiter;

  logic       clk;
  logic       rst_n;
  logic [3:0] req_a   [3];
  logic       en_a    [3];
  logic       done_a  [3];
  logic [3:0] grant_a [3];
  logic [1:0] idx_a   [3];
  logic       busy_a  [3];
  logic       to_a    [3];

  int checks;
  int failures;

  typedef struct {
    int         id;
    logic [3:0] grant;
    logic [1:0] idx;
    logic       to;
    int         delta;
  } ev_t;

  ev_t exp_q[$];

  rr_arbiter #(.WIDTH(4), .MODE(0), .HOLD_MAX(0)) u_rr (
    .clk(clk), .rst_n(rst_n), .enable(en_a[0]), .req(req_a[0]), .done(done_a[0]),
    .grant(grant_a[0]), .grant_idx(idx_a[0]), .busy(busy_a[0]), .timeout(to_a[0]));

  rr_arbiter #(.WIDTH(4), .MODE(1), .HOLD_MAX(0)) u_fp (
    .clk(clk), .rst_n(rst_n), .enable(en_a[1]), .req(req_a[1]), .done(done_a[1]),
    .grant(grant_a[1]), .grant_idx(idx_a[1]), .busy(busy_a[1]), .timeout(to_a[1]));

  rr_arbiter #(.WIDTH(4), .MODE(0), .HOLD_MAX(8)) u_to (
    .clk(clk), .rst_n(rst_n), .enable(en_a[2]), .req(req_a[2]), .done(done_a[2]),
    .grant(grant_a[2]), .grant_idx(idx_a[2]), .busy(busy_a[2]), .timeout(to_a[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic push(input int id, input logic [3:0] g, input logic [1:0] idx,
                      input logic to, input int delta);
    ev_t e;
    e.id = id; e.grant = g; e.idx = idx; e.to = to; e.delta = delta;
    exp_q.push_back(e);
  endtask

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%b expected=%b", name, act, exp);
    end
  endtask

  task automatic wait_busy(input int d);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!busy_a[d] && n < 20);
    checks++;
    if (!busy_a[d]) begin
      failures++;
      $display("FAIL wait_busy dut=%0d actual=busy0 expected=busy1 within 20 cycles", d);
    end
  endtask

  task automatic pulse_done(input int d);
    done_a[d] = 1'b1;
    @(negedge clk);
    #1 done_a[d] = 1'b0;
  endtask

  // Monitor: every grant change or timeout pulse must match the next expected event
  initial begin
    logic [3:0] prev_g [3];
    int ncyc;
    int last_ev;
    ev_t e;
    ncyc = 0;
    last_ev = 0;
    for (int d = 0; d < 3; d++) prev_g[d] = 4'b0000;
    forever begin
      @(negedge clk);
      ncyc++;
      for (int d = 0; d < 3; d++) begin
        if (grant_a[d] !== prev_g[d] || to_a[d] === 1'b1) begin
          checks++;
          if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL unexpected_event dut=%0d grant=%b idx=%0d timeout=%b", d, grant_a[d], idx_a[d], to_a[d]);
          end else begin
            e = exp_q.pop_front();
            if (e.id != d || e.grant !== grant_a[d] || e.idx !== idx_a[d] ||
                busy_a[d] !== (|e.grant) || e.to !== to_a[d] ||
                (e.delta >= 0 && e.delta != ncyc - last_ev)) begin
              failures++;
              $display("FAIL event dut=%0d actual grant=%b idx=%0d busy=%b to=%b gap=%0d expected dut=%0d grant=%b idx=%0d to=%b gap=%0d",
                       d, grant_a[d], idx_a[d], busy_a[d], to_a[d], ncyc - last_ev,
                       e.id, e.grant, e.idx, e.to, e.delta);
            end
          end
          last_ev = ncyc;
          prev_g[d] = grant_a[d];
        end
      end
    end
  end

  initial begin
    checks = 0;
    failures = 0;
    rst_n = 1'b0;
    for (int d = 0; d < 3; d++) begin
      req_a[d] = 4'b0000; en_a[d] = 1'b1; done_a[d] = 1'b0;
    end
    #12;
    for (int d = 0; d < 3; d++)
      chk($sformatf("reset_outputs_dut%0d", d), {grant_a[d], idx_a[d], busy_a[d], to_a[d]}, 8'h00);
    @(negedge clk);
    #1 rst_n = 1'b1;

    // Reset release, then rotation with REQ=1111 (first grant holds despite other requests)
    push(0, 4'b0001, 2'd0, 1'b0, -1); push(0, 4'b0000, 2'd0, 1'b0, 1);
    push(0, 4'b0010, 2'd1, 1'b0, 1);  push(0, 4'b0000, 2'd0, 1'b0, 1);
    push(0, 4'b0100, 2'd2, 1'b0, 1);  push(0, 4'b0000, 2'd0, 1'b0, 1);
    push(0, 4'b1000, 2'd3, 1'b0, 1);  push(0, 4'b0000, 2'd0, 1'b0, 1);
    push(0, 4'b0001, 2'd0, 1'b0, 1);  push(0, 4'b0000, 2'd0, 1'b0, 1);
    @(negedge clk);
    #1 req_a[0] = 4'b0001;
    wait_busy(0);
    chk("first_grant", {grant_a[0], idx_a[0], busy_a[0], to_a[0]}, {4'b0001, 2'd0, 1'b1, 1'b0});
    #1 req_a[0] = 4'b1111;
    pulse_done(0);
    for (int k = 1; k < 5; k++) begin
      wait_busy(0);
      #1 pulse_done(0);
    end
    req_a[0] = 4'b0000;

    // ENABLE low blocks grants; DONE in IDLE is ignored
    en_a[0] = 1'b0; req_a[0] = 4'b1111; done_a[0] = 1'b1;
    repeat (4) @(negedge clk);
    chk("enable_low_blocks", {grant_a[0], idx_a[0], busy_a[0], to_a[0]}, 8'h00);
    #1 done_a[0] = 1'b0; req_a[0] = 4'b0000; en_a[0] = 1'b1;
    repeat (2) @(negedge clk);

    // Fixed priority: REQ=1010 always wins channel 1
    for (int k = 0; k < 3; k++) begin
      push(1, 4'b0010, 2'd1, 1'b0, (k == 0) ? -1 : 1);
      push(1, 4'b0000, 2'd0, 1'b0, 1);
    end
    #1 req_a[1] = 4'b1010;
    for (int k = 0; k < 3; k++) begin
      wait_busy(1);
      #1 pulse_done(1);
    end
    req_a[1] = 4'b0000;
    repeat (2) @(negedge clk);

    // Hold limit: timeout, request drop, DONE coincident with expiry
    push(2, 4'b0001, 2'd0, 1'b0, -1); push(2, 4'b0000, 2'd0, 1'b1, 8);
    push(2, 4'b0100, 2'd2, 1'b0, 1);  push(2, 4'b0000, 2'd0, 1'b0, 2);
    push(2, 4'b0001, 2'd0, 1'b0, 1);  push(2, 4'b0000, 2'd0, 1'b0, 8);
    #1 req_a[2] = 4'b0101;
    wait_busy(2);
    repeat (10) @(negedge clk);
    #1 req_a[2] = 4'b0001;
    repeat (9) @(negedge clk);
    #1 done_a[2] = 1'b1;
    @(negedge clk);
    #1 done_a[2] = 1'b0; req_a[2] = 4'b0000;
    repeat (2) @(negedge clk);

    // Async reset mid-grant with BASE at channel 2
    push(0, 4'b0010, 2'd1, 1'b0, -1); push(0, 4'b0000, 2'd0, 1'b0, 1);
    push(0, 4'b0100, 2'd2, 1'b0, 1);  push(0, 4'b0000, 2'd0, 1'b0, -1);
    push(0, 4'b0001, 2'd0, 1'b0, 1);  push(0, 4'b0000, 2'd0, 1'b0, 1);
    #1 req_a[0] = 4'b0010;
    wait_busy(0);
    #1 pulse_done(0);
    req_a[0] = 4'b1111;
    wait_busy(0);
    chk("grant_from_base2", {grant_a[0], idx_a[0], busy_a[0], to_a[0]}, {4'b0100, 2'd2, 1'b1, 1'b0});
    #3 rst_n = 1'b0;
    #1 chk("async_reset_drop", {grant_a[0], idx_a[0], busy_a[0], to_a[0]}, 8'h00);
    @(negedge clk);
    #1 rst_n = 1'b1;
    wait_busy(0);
    chk("restart_from_bit0", {grant_a[0], idx_a[0], busy_a[0], to_a[0]}, {4'b0001, 2'd0, 1'b1, 1'b0});
    #1 pulse_done(0);
    req_a[0] = 4'b0000;

    for (int i = 0; i < 50 && exp_q.size() != 0; i++) @(negedge clk);
    repeat (3) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain actual=%0d pending expected=0 pending", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/rr_arbiter.md
RR_ARBITER -- requirements
Module: rr_arbiter

Interface
REQ-001 Parameter WIDTH, default 4, number of requesting channels (>=2).
REQ-002 Parameter MODE, default 0, 0 = round-robin (rotating base), 1 = fixed priority (lowest index wins).
REQ-003 Parameter HOLD_MAX, default 0, max cycles a grant may be held; 0 = unlimited.
REQ-004 Local IDX_W SHALL be clog2(WIDTH).
REQ-005 CLK  input  1  single clock; all state on rising edge.
REQ-006 RST_N  input  1  reset, asynchronous, active-low.
REQ-007 ENABLE  input  1  high permits new grants.
REQ-008 REQ  input  WIDTH  per-channel request, level-sensitive.
REQ-009 DONE  input  1  granted channel finished; sampled only in GRANT state.
REQ-010 GRANT  output  WIDTH  registered one-hot grant, or all zero.
REQ-011 GRANT_IDX  output  IDX_W  binary index of granted channel; 0 when no grant.
REQ-012 BUSY  output  1  high while any GRANT bit is high.
REQ-013 TIMEOUT  output  1  one-cycle pulse when a grant is force-released by HOLD_MAX.

Function
REQ-014 FSM SHALL have two states: IDLE (GRANT=0) and GRANT (exactly one GRANT bit high).
REQ-015 Internal one-hot BASE register SHALL mark the first channel considered; search runs upward from BASE, wrapping MSB -> bit 0.
REQ-016 IDLE -> GRANT when ENABLE=1 and REQ!=0; GRANT SHALL appear the cycle after REQ is sampled (latency 1).
REQ-017 Selected channel SHALL be the first REQ bit at or above BASE, else the lowest REQ bit below BASE.
REQ-018 In GRANT, GRANT/GRANT_IDX SHALL hold constant regardless of other REQ bits or ENABLE.
REQ-019 GRANT -> IDLE on the cycle after any of: DONE=1; granted REQ bit=0; hold counter reaching HOLD_MAX (HOLD_MAX>0).
REQ-020 Hold counter SHALL clear on entry to GRANT and count granted cycles; width clog2(HOLD_MAX+1), min 1; no wrap.
REQ-021 TIMEOUT SHALL pulse in the same cycle GRANT drops, only for a HOLD_MAX release; DONE or REQ-drop in the same cycle as expiry SHALL suppress TIMEOUT.
REQ-022 On release with MODE=0, BASE SHALL become the one-hot bit above the released channel (channel WIDTH-1 wraps to bit 0).
REQ-023 With MODE=1, BASE SHALL stay bit 0 permanently.
REQ-024 After release, at least one IDLE cycle with GRANT=0 SHALL occur before the next grant (no back-to-back grants).
REQ-025 DONE in IDLE SHALL be ignored.
REQ-026 ENABLE low in IDLE SHALL block new grants; REQ is not latched.
REQ-027 BUSY SHALL equal |GRANT, registered with GRANT.

Reset
REQ-028 RST_N low SHALL immediately force IDLE, GRANT=0, GRANT_IDX=0, BUSY=0, TIMEOUT=0, hold counter=0, BASE=bit 0.
REQ-029 Reset asserted mid-grant SHALL drop GRANT asynchronously with no TIMEOUT pulse; after deassertion arbitration restarts from bit 0.

Verification (WIDTH=4 unless stated)
REQ-030 Reset: RST_N=0 -> all outputs 0; release, REQ=0001, ENABLE=1 -> GRANT=0001, GRANT_IDX=0, BUSY=1 one cycle later.
REQ-031 Rotation: REQ=1111 held, DONE pulsed each grant -> GRANT sequence 0001,0010,0100,1000,0001, each separated by one all-zero cycle.
REQ-032 Fixed priority: MODE=1, REQ=1010 held, DONE each grant -> GRANT always 0010, GRANT_IDX=1.
REQ-033 Timeout: HOLD_MAX=8, REQ=0101, no DONE -> GRANT=0001 for 8 cycles, TIMEOUT=1 for 1 cycle as GRANT drops, next GRANT=0100.
REQ-034 Request drop / simultaneous: granted REQ bit cleared mid-grant -> GRANT=0 next cycle, TIMEOUT=0; DONE coincident with HOLD_MAX expiry -> release with TIMEOUT=0.
REQ-035 Async reset mid-grant with BASE=0100 -> GRANT=0 without clock edge; after release REQ=1111 -> GRANT=0001.
